// File: rtl/int_pulse_cond.sv
// Interrupt conditioner placed in front of the CPU's two interrupt inputs.
// Each asynchronous pin is synchronised and edge-detected. Events are counted
// per channel and replayed as fixed-width, non-overlapping request pulses.
// Channel A has priority over channel B.
module int_pulse_cond #(
  parameter int SYNC_STAGES  = 2,  // synchroniser depth, 2..4
  parameter int PULSE_CYCLES = 4,  // output pulse width in clocks, 1..15
  parameter int GAP_CYCLES   = 2,  // minimum low clocks between pulses, 0..15
  parameter int PEND_W       = 2   // per-channel pending counter width
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       i_int_a_raw,
  input  logic       i_int_b_raw,
  input  logic [1:0] i_en,
  input  logic       i_ovf_clr,
  output logic       o_inta,
  output logic       o_intb,
  output logic [1:0] o_ovf,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE_A = 2'd1,
    PULSE_B = 2'd2,
    GAP     = 2'd3
  } state_t;

  localparam logic [PEND_W-1:0] PEND_MAX   = '1;
  localparam logic [PEND_W-1:0] PEND_ONE   = PEND_W'(1);
  localparam logic [3:0]        PULSE_LOAD = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0]        GAP_LOAD   = 4'(GAP_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_a;
  logic [SYNC_STAGES-1:0] sync_b;
  logic                   hist_a;
  logic                   hist_b;
  // Fills with ones after reset; the top bit marks the point where both the
  // synchroniser output and its history hold real pin samples. Until then no
  // edge is reported, so a pin already high at reset release is not an event.
  logic [SYNC_STAGES:0]   arm;

  logic [1:0]             ev;
  logic [1:0]             deq;
  logic [1:0]             ovf_set;
  logic [1:0][PEND_W-1:0] pend;
  logic [1:0][PEND_W-1:0] pend_nxt;

  state_t                 state;
  logic [3:0]             cnt;

  // Synchroniser chains, edge history and the post-reset arming shift register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_a <= '0;
      sync_b <= '0;
      hist_a <= 1'b0;
      hist_b <= 1'b0;
      arm    <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], i_int_a_raw};
      sync_b <= {sync_b[SYNC_STAGES-2:0], i_int_b_raw};
      hist_a <= sync_a[SYNC_STAGES-1];
      hist_b <= sync_b[SYNC_STAGES-1];
      arm    <= {arm[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign ev = {arm[SYNC_STAGES] & sync_b[SYNC_STAGES-1] & ~hist_b,
               arm[SYNC_STAGES] & sync_a[SYNC_STAGES-1] & ~hist_a};

  // The FSM takes one event per visit to IDLE, A first.
  assign deq = {(state == IDLE) && (pend[0] == '0) && (pend[1] != '0),
                (state == IDLE) && (pend[0] != '0)};

  assign o_busy = (state != IDLE) || (pend[0] != '0) || (pend[1] != '0);

  // Next pending count and overflow request per channel.
  // NOTE: every variable gets a default before the branches, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    pend_nxt = pend;
    ovf_set  = '0;
    for (int i = 0; i < 2; i++) begin
      if (!i_en[i]) begin
        pend_nxt[i] = '0;
      end else if (ev[i]) begin
        if (pend[i] == PEND_MAX) begin
          // A saturated queue drops the event even if one leaves this cycle.
          ovf_set[i] = 1'b1;
          if (deq[i]) pend_nxt[i] = pend[i] - PEND_ONE;
        end else if (!deq[i]) begin
          pend_nxt[i] = pend[i] + PEND_ONE;
        end
      end else if (deq[i]) begin
        pend_nxt[i] = pend[i] - PEND_ONE;
      end
    end
  end

  // Pending counters and sticky overflow flags; a new overflow beats a clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pend  <= '0;
      o_ovf <= 2'b00;
    end else begin
      pend  <= pend_nxt;
      o_ovf <= ovf_set | (o_ovf & ~{2{i_ovf_clr}});
    end
  end

  // Pulse sequencer. The request outputs are registered copies of the pulse
  // states, so each output pulse trails its state by one clock and has exactly
  // the state's length and spacing.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      o_inta <= 1'b0;
      o_intb <= 1'b0;
    end else begin
      o_inta <= (state == PULSE_A);
      o_intb <= (state == PULSE_B);
      case (state)
        IDLE: begin
          if (pend[0] != '0) begin
            state <= PULSE_A;
            cnt   <= PULSE_LOAD;
          end else if (pend[1] != '0) begin
            state <= PULSE_B;
            cnt   <= PULSE_LOAD;
          end
        end
        PULSE_A, PULSE_B: begin
          if (cnt == 4'd0) begin
            if (GAP_CYCLES == 0) begin
              state <= IDLE;
            end else begin
              state <= GAP;
              cnt   <= GAP_LOAD;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        GAP: begin
          if (cnt == 4'd0) state <= IDLE;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_pulse_cond.sv
// Directed bench for int_pulse_cond. A default build and a GAP_CYCLES = 0 build
// share all inputs. Output waveforms are captured once per clock on the falling
// edge; index i of a capture holds the outputs after rising edge i, where edge 0
// is the first edge that samples the new raw pin level.
module tb_int_pulse_cond;

  localparam int WIN = 80;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       raw_a;
  logic       raw_b;
  logic [1:0] en;
  logic       ovf_clr;
  logic       inta, intb, busy;
  logic [1:0] ovf;
  logic       g_inta, g_intb, g_busy;
  logic [1:0] g_ovf;

  int vectors     = 0;
  int miscompares = 0;

  logic [WIN-1:0] a_v, b_v, busy_v, g_v;

  always #10 clk = ~clk;

  int_pulse_cond dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .i_int_a_raw (raw_a),
    .i_int_b_raw (raw_b),
    .i_en        (en),
    .i_ovf_clr   (ovf_clr),
    .o_inta      (inta),
    .o_intb      (intb),
    .o_ovf       (ovf),
    .o_busy      (busy)
  );

  int_pulse_cond #(.GAP_CYCLES(0)) dut_g0 (
    .clk         (clk),
    .n_rst       (n_rst),
    .i_int_a_raw (raw_a),
    .i_int_b_raw (raw_b),
    .i_en        (en),
    .i_ovf_clr   (ovf_clr),
    .o_inta      (g_inta),
    .o_intb      (g_intb),
    .o_ovf       (g_ovf),
    .o_busy      (g_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic capture(input int n);
    a_v = '0; b_v = '0; busy_v = '0; g_v = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a_v[i]    = inta;
      b_v[i]    = intb;
      busy_v[i] = busy;
      g_v[i]    = g_inta;
    end
  endtask

  // Index of the k-th rising transition in a capture, -1 if absent.
  function automatic int nth_rise(input logic [WIN-1:0] v, input int k);
    int   c    = 0;
    logic prev = 1'b0;
    for (int i = 0; i < WIN; i++) begin
      if (v[i] && !prev) begin
        c++;
        if (c == k) return i;
      end
      prev = v[i];
    end
    return -1;
  endfunction

  function automatic int rises(input logic [WIN-1:0] v);
    int   c    = 0;
    logic prev = 1'b0;
    for (int i = 0; i < WIN; i++) begin
      if (v[i] && !prev) c++;
      prev = v[i];
    end
    return c;
  endfunction

  function automatic int width_at(input logic [WIN-1:0] v, input int start);
    int w = 0;
    if (start < 0) return 0;
    for (int i = start; i < WIN; i++) begin
      if (!v[i]) break;
      w++;
    end
    return w;
  endfunction

  function automatic int last_high(input logic [WIN-1:0] v);
    int idx = -1;
    for (int i = 0; i < WIN; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  task automatic a_train(input int n);
    for (int k = 0; k < n; k++) begin
      raw_a = 1'b1;
      @(negedge clk);
      raw_a = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || g_busy || inta || intb || g_inta || g_intb) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("idle_wait_timeout", 32'(t >= 200), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_rst = 1'b0; raw_a = 1'b0; raw_b = 1'b0; en = 2'b11; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_inta", inta, 0);
    check("rst_intb", intb, 0);
    check("rst_ovf",  ovf,  0);
    check("rst_busy", busy, 0);
    check("rst_g0_inta", g_inta, 0);
    n_rst = 1'b1;
    repeat (5) @(negedge clk);

    // Single 25 ns pulse on A.
    @(negedge clk);
    fork begin raw_a = 1'b1; #25; raw_a = 1'b0; end join_none
    capture(30);
    check("t1_a_rise",      nth_rise(a_v, 1), 4);
    check("t1_a_width",     width_at(a_v, 4), 4);
    check("t1_a_pulses",    rises(a_v), 1);
    check("t1_b_pulses",    rises(b_v), 0);
    check("t1_busy_rise",   nth_rise(busy_v, 1), 2);
    check("t1_busy_last",   last_high(busy_v), 8);
    wait_idle();

    // A and B in the same cycle: A first, three low cycles, then B.
    @(negedge clk);
    fork begin raw_a = 1'b1; raw_b = 1'b1; #25; raw_a = 1'b0; raw_b = 1'b0; end join_none
    capture(30);
    check("t2_a_rise",  nth_rise(a_v, 1), 4);
    check("t2_a_width", width_at(a_v, 4), 4);
    check("t2_b_rise",  nth_rise(b_v, 1), 11);
    check("t2_b_width", width_at(b_v, 11), 4);
    check("t2_overlap", $countones(a_v & b_v), 0);
    wait_idle();

    // Five A edges two clocks apart: queue saturates, fifth event overflows.
    @(negedge clk);
    fork a_train(5); join_none
    capture(60);
    check("t3_a_pulses", rises(a_v), 4);
    check("t3_a_rise2",  nth_rise(a_v, 2), 11);
    check("t3_a_rise4",  nth_rise(a_v, 4), 25);
    check("t3_ovf_set",  ovf, 2'b01);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    check("t3_ovf_clr",  ovf, 2'b00);
    wait_idle();

    // Same stream with the clear landing on the overflow edge: the set wins.
    @(negedge clk);
    fork
      a_train(5);
      begin repeat (10) @(negedge clk); ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0; end
    join_none
    capture(60);
    check("t3b_a_pulses",  rises(a_v), 4);
    check("t3b_set_wins",  ovf, 2'b01);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    check("t3b_ovf_clr",   ovf, 2'b00);
    wait_idle();

    // B disabled: its edge is dropped and nothing is queued.
    en = 2'b01;
    @(negedge clk);
    fork begin raw_b = 1'b1; #25; raw_b = 1'b0; end join_none
    capture(20);
    check("t4_b_pulses", rises(b_v), 0);
    check("t4_b_busy",   rises(busy_v), 0);
    // Two A events, A disabled mid-pulse: pulse completes, second is flushed.
    @(negedge clk);
    fork
      a_train(2);
      begin repeat (5) @(negedge clk); en = 2'b00; end
    join_none
    capture(30);
    check("t4_a_pulses",    rises(a_v), 1);
    check("t4_a_width",     width_at(a_v, 4), 4);
    check("t4_busy_last",   last_high(busy_v), 8);
    en = 2'b11;
    wait_idle();

    // Reset during the second pulse cycle, raw pin held high.
    @(negedge clk);
    raw_a = 1'b1;
    capture(6);
    check("t5_mid_pulse", a_v[5], 1);
    n_rst = 1'b0;
    #1;
    check("t5_async_inta", inta, 0);
    check("t5_async_busy", busy, 0);
    @(negedge clk);
    n_rst = 1'b1;
    capture(30);
    check("t5_held_pulses", rises(a_v), 0);
    raw_a = 1'b0;
    repeat (4) @(negedge clk);
    fork begin raw_a = 1'b1; #25; raw_a = 1'b0; end join_none
    capture(30);
    check("t5_new_rise",  nth_rise(a_v, 1), 4);
    check("t5_new_width", width_at(a_v, 4), 4);
    wait_idle();

    // Pin held high for 50 clocks gives one pulse.
    @(negedge clk);
    fork begin raw_a = 1'b1; repeat (50) @(negedge clk); raw_a = 1'b0; end join_none
    capture(70);
    check("t6_a_pulses", rises(a_v), 1);
    check("t6_a_rise",   nth_rise(a_v, 1), 4);
    wait_idle();

    // Two queued A events: one low clock apart without a gap, three with it.
    @(negedge clk);
    fork a_train(2); join_none
    capture(30);
    check("t7_g0_pulses", rises(g_v), 2);
    check("t7_g0_rise1",  nth_rise(g_v, 1), 4);
    check("t7_g0_width",  width_at(g_v, 4), 4);
    check("t7_g0_rise2",  nth_rise(g_v, 2), 9);
    check("t7_def_rise2", nth_rise(a_v, 2), 11);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/int_pulse_cond.md
Name: int_pulse_cond

Overview:
- Interrupt conditioner directly upstream of the CPU top's i_inta / i_intb inputs.
- Takes asynchronous external interrupt pins, whose pulses may be shorter than one clock.
- Synchronises each pin, detects rising edges, queues events per channel, and replays them to the CPU as clean, fixed-width, non-overlapping request pulses.
- Channel A has priority over channel B. Queue overflow is flagged.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per raw input (legal 2..4).
- PULSE_CYCLES, 4, width in clocks of each o_inta/o_intb pulse (legal 1..15).
- GAP_CYCLES, 2, minimum low clocks between consecutive output pulses (legal 0..15).
- PEND_W, 2, width of each per-channel pending counter; saturates at 2^PEND_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- i_int_a_raw  input  1  asynchronous interrupt pin A.
- i_int_b_raw  input  1  asynchronous interrupt pin B.
- i_en  input  2  channel enable; bit0 = A, bit1 = B.
- i_ovf_clr  input  1  synchronous clear of o_ovf, one-cycle strobe.
- o_inta  output  1  conditioned request A to CPU, registered.
- o_intb  output  1  conditioned request B to CPU, registered.
- o_ovf  output  2  sticky overflow flags; bit0 = A, bit1 = B.
- o_busy  output  1  high whenever state is not IDLE or any pending count is non-zero.

Behaviour:
- Interface: one clock clk; reset n_rst is asynchronous and active-low.
- Reset: n_rst low asynchronously clears all of the following, at any time including mid-pulse:
  - synchroniser flops, edge history, pending counters, FSM (to IDLE), cycle counter;
  - o_inta = 0, o_intb = 0, o_ovf = 2'b00, o_busy = 0.
  - After release, a raw pin already high does not produce an event; an edge is required.
- Synchroniser: each raw pin passes through a SYNC_STAGES flop chain.
- Edge detect: ev_x = sync_x & ~sync_x_d (prev sample).
  - Exactly one event per low-to-high transition, regardless of how long the pin stays high.
  - A raw pulse at least one clock period wide is guaranteed to be captured.
- Pending counters:
  - ev_x with i_en[x] = 1 increments pend_x.
  - ev_x with i_en[x] = 0 is dropped.
  - i_en[x] = 0 also clears pend_x on the next edge. A pulse already in progress completes.
  - At saturation, an event leaves pend_x unchanged and sets o_ovf[x].
  - Increment and FSM dequeue in the same cycle: net unchanged, with no overflow unless already saturated before the cycle.
  - o_ovf[x] is cleared by i_ovf_clr. A set in the same cycle as the clear wins.
- FSM states: IDLE, PULSE_A, PULSE_B, GAP.
- IDLE:
  - if pend_a > 0: go to PULSE_A and decrement pend_a;
  - else if pend_b > 0: go to PULSE_B and decrement pend_b.
  - Decisions use the registered counter values, so an event counted at edge k is seen at edge k+1.
- PULSE_A / PULSE_B:
  - o_inta / o_intb is high for exactly PULSE_CYCLES clocks, starting the cycle after leaving IDLE.
  - Exit to GAP, or to IDLE if GAP_CYCLES = 0.
- GAP: both outputs low for GAP_CYCLES clocks, then IDLE.
  - Back-to-back pulse spacing is therefore GAP_CYCLES + 1 low clocks (the IDLE decision cycle).
- o_inta and o_intb are never high in the same cycle.
- Latency:
  - Take the first rising clk edge that samples a raw pin high as edge 0, with the FSM idle and the channel enabled.
  - Output rises after edge SYNC_STAGES + 2. With default parameters that is edge 4, i.e. 4 clocks.
- Priority: if A and B events become pending in the same cycle, A is served first and B follows after the gap.
  - A continuous stream of A events starves B; this is by design.
- Outputs are flop-driven only; no combinational path from any input to o_inta/o_intb.

Test Plan:
- Reset then a single 25 ns pulse on i_int_a_raw (clk 20 ns), i_en = 2'b11 -> o_inta high for exactly 4 cycles, rising 4 edges after capture; o_intb stays 0; o_busy falls after the gap.
- A and B raw pulses in the same cycle -> 4-cycle o_inta, then 3 low cycles, then 4-cycle o_intb; outputs never overlap.
- Five A edges spaced 2 cycles apart while busy, PEND_W = 2 -> outputs:
  - the first edge is dequeued at once, so pend_a then reaches 3 and saturates;
  - 4 o_inta pulses total; o_ovf = 2'b01.
  - i_ovf_clr -> o_ovf = 2'b00, unless an overflow occurs in the same cycle, in which case it stays set.
- i_en = 2'b01 with a B edge -> no o_intb and pend_b stays 0. Then queue 2 A events and clear i_en[0] mid-pulse -> current pulse completes; the remaining A event is flushed.
- n_rst asserted during PULSE_A, cycle 2 -> o_inta = 0 immediately (asynchronously). After release, the raw pin held high gives no pulse; a new edge gives the normal 4-cycle pulse.
- Raw A held high for 50 cycles -> exactly one o_inta pulse. GAP_CYCLES = 0 build -> two queued A events give pulses separated by 1 low cycle.
